// File: rtl/leap_mem_loader.sv
// rtl/leap_mem_loader.sv - streams upstream words into a RAM port and pulses done to start the kernel
//
// Purpose:
//   A load_start request captures a base word address and a word count. The
//   loader then accepts that many words from a valid/ready stream and writes
//   them to consecutive RAM addresses. The address wraps at 2^ADDR_W. When the
//   last word is accepted, done pulses for one cycle.
//
// Ports:
//   clk, reset                     clock; asynchronous active-low reset
//   load_start, base_addr, length  transfer request (length 0 goes straight to done)
//   memory_controller_waitrequest  memory-side stall; freezes the RAM port and intake
//   s_valid, s_data, s_ready       upstream word stream
//   mem_enable, mem_write_enable,
//   mem_address, mem_in,
//   mem_byteena                    registered RAM port-a write interface
//   busy, done                     transfer in progress / one-cycle completion pulse
//   checksum                       running sum of loaded words
//
// Configuration:
//   LEAP_LOADER_CHECKSUM_EN  when defined, checksum accumulates the accepted
//                            words (modulo 2^32). When it is undefined,
//                            checksum is tied to 0.

module leap_mem_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              memory_controller_waitrequest,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              mem_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_byteena,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_cnt;
    logic [LEN_W-1:0]  remaining;
    logic              start_take;
    logic              accept;
    logic              last_accept;

    // A request is taken only in IDLE. A load_start in LOAD or DONE is ignored.
    assign start_take  = (state == ST_IDLE) && load_start;
    assign accept      = s_valid && s_ready;
    assign last_accept = accept && (remaining == LEN_W'(1));
    assign mem_byteena = 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_start) begin
                    state_next = (length == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy    = 1'b1;
                s_ready = !memory_controller_waitrequest && (remaining != '0);
                if (last_accept) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_cnt  <= '0;
            remaining <= '0;
        end else if (start_take) begin
            addr_cnt  <= base_addr;
            remaining <= length;
        end else if (accept) begin
            addr_cnt  <= addr_cnt + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
        end
    end

    // The write port is registered one cycle behind the accept.
    // While waitrequest is high, the whole port holds its values, so a write
    // already presented to the memory stays presented until the memory takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_enable       <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_in           <= '0;
        end else if (!memory_controller_waitrequest) begin
            mem_enable       <= accept;
            mem_write_enable <= accept;
            if (accept) begin
                mem_address <= addr_cnt;
                mem_in      <= s_data;
            end
        end
    end

`ifdef LEAP_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    // The sum restarts on every accepted request, including length 0.
    // After done it holds until the next request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else if (start_take) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + 32'(s_data);
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_leap_mem_loader.sv
// tb/tb_leap_mem_loader.sv - randomized scoreboard bench for leap_mem_loader

module tb_leap_mem_loader;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        waitrequest;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        mem_enable;
    logic        mem_write_enable;
    logic [9:0]  mem_address;
    logic [31:0] mem_in;
    logic        mem_byteena;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    int vectors;
    int miscompares;

    logic [31:0] src[$];
    logic [9:0]  exp_a[$];
    logic [31:0] exp_d[$];
    logic [9:0]  got_a[$];
    logic [31:0] got_d[$];

    bit          mon_en;
    bit          prev_ok;
    bit          prev_wr;
    logic [43:0] prev_bus;

    leap_mem_loader #(.ADDR_W(10), .DATA_W(32), .LEN_W(11)) dut (
        .clk                           (clk),
        .reset                         (rst_n),
        .load_start                    (load_start),
        .base_addr                     (base_addr),
        .length                        (length),
        .memory_controller_waitrequest (waitrequest),
        .s_valid                       (s_valid),
        .s_data                        (s_data),
        .s_ready                       (s_ready),
        .mem_enable                    (mem_enable),
        .mem_write_enable              (mem_write_enable),
        .mem_address                   (mem_address),
        .mem_in                        (mem_in),
        .mem_byteena                   (mem_byteena),
        .busy                          (busy),
        .done                          (done),
        .checksum                      (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The RAM port takes a write in any cycle where it is enabled and not stalled.
    // During a stall, the port must hold its values unchanged across the edge.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (prev_ok && prev_wr) begin
                vectors++;
                if ({mem_enable, mem_write_enable, mem_address, mem_in} !== prev_bus) begin
                    miscompares++;
                    $display("FAIL stall_hold: got %h expected %h", {mem_enable, mem_write_enable, mem_address, mem_in}, prev_bus);
                end
            end
            vectors++;
            if (mem_write_enable !== mem_enable || mem_byteena !== 1'b1) begin
                miscompares++;
                $display("FAIL strobes: got en=%b we=%b be=%b expected we=en be=1", mem_enable, mem_write_enable, mem_byteena);
            end
            if (mem_enable === 1'b1 && !waitrequest) begin
                got_a.push_back(mem_address);
                got_d.push_back(mem_in);
            end
            prev_bus = {mem_enable, mem_write_enable, mem_address, mem_in};
            prev_wr  = waitrequest;
            prev_ok  = 1'b1;
        end else begin
            prev_ok = 1'b0;
        end
    end

    task automatic fill_random(input int n);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back($urandom);
    endtask

    // One complete transfer of the words in src, checked against the scoreboard.
    task automatic run_xfer(input logic [9:0] base, input logic [10:0] len, input int wr_pct,
                            input int v_pct, input bit extra_start, input int stall_at);
        logic [31:0] sum;
        logic [31:0] exp_cs;
        logic [9:0]  a;
        int          sent;
        int          cyc;
        bit          exp_done;
        bit          acc;
        exp_a.delete(); exp_d.delete(); got_a.delete(); got_d.delete();
        sum = 0;
        a   = base;
        for (int i = 0; i < int'(len); i++) begin
            exp_a.push_back(a);
            exp_d.push_back(src[i]);
            sum = sum + src[i];
            a   = a + 10'd1;
        end
        @(negedge clk);
        load_start = 1'b1; base_addr = base; length = len; s_valid = 1'b0; waitrequest = 1'b0;
        @(negedge clk);
        load_start = 1'b0;
        vectors++;
        if (done !== (len == 0)) begin
            miscompares++;
            $display("FAIL start_done: got %b expected %b", done, (len == 0));
        end
        vectors++;
        if (busy !== (len != 0)) begin
            miscompares++;
            $display("FAIL start_busy: got %b expected %b", busy, (len != 0));
        end
        sent     = 0;
        cyc      = 0;
        exp_done = (len == 0);
        while (!exp_done && cyc < 2000) begin
            if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3) waitrequest = 1'b1;
            else waitrequest = ($urandom_range(99) < wr_pct);
            s_valid    = (sent < int'(len)) && ($urandom_range(99) < v_pct);
            s_data     = s_valid ? src[sent] : $urandom;
            load_start = extra_start && ($urandom_range(3) == 0);
            base_addr  = $urandom;
            length     = $urandom;
            #1;
            vectors++;
            if (s_ready !== (!waitrequest && sent < int'(len))) begin
                miscompares++;
                $display("FAIL s_ready: got %b expected %b (cyc %0d)", s_ready, (!waitrequest && sent < int'(len)), cyc);
            end
            acc = s_valid && !waitrequest;
            if (acc) sent++;
            exp_done = acc && (sent == int'(len));
            @(negedge clk);
            cyc++;
            vectors++;
            if (done !== exp_done) begin
                miscompares++;
                $display("FAIL done_timing: got %b expected %b (cyc %0d)", done, exp_done, cyc);
            end
            vectors++;
            if (busy !== (sent < int'(len))) begin
                miscompares++;
                $display("FAIL busy: got %b expected %b (cyc %0d)", busy, (sent < int'(len)), cyc);
            end
        end
        if (!exp_done) begin
            miscompares++;
            $display("FAIL xfer_timeout: got %0d words expected %0d", sent, len);
        end
        waitrequest = 1'b0; s_valid = 1'b0; load_start = 1'b0;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
        repeat (2) @(negedge clk);
        #3;
        vectors++;
        if (got_a.size() != exp_a.size()) begin
            miscompares++;
            $display("FAIL write_count: got %0d expected %0d", got_a.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            vectors++;
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
                miscompares++;
                $display("FAIL write[%0d]: got %0d/%h expected %0d/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
            end
        end
`ifdef LEAP_LOADER_CHECKSUM_EN
        exp_cs = sum;
`else
        exp_cs = 32'd0;
`endif
        vectors++;
        if (checksum !== exp_cs) begin
            miscompares++;
            $display("FAIL checksum: got %h expected %h", checksum, exp_cs);
        end
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({s_ready, mem_enable, mem_write_enable, mem_address, mem_in, busy, done, checksum} !== '0) begin
            miscompares++;
            $display("FAIL %s: got rdy=%b en=%b we=%b a=%h d=%h busy=%b done=%b cs=%h expected all 0",
                     tag, s_ready, mem_enable, mem_write_enable, mem_address, mem_in, busy, done, checksum);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_start = 1'b0; base_addr = '0; length = '0;
        waitrequest = 1'b0; s_valid = 1'b0; s_data = '0;
        #3;
        check_all_zero("reset_state");
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        src.delete();
        src.push_back(32'hA); src.push_back(32'hB); src.push_back(32'hC);
        run_xfer(10'd5, 11'd3, 0, 100, 1'b0, -1);
    endtask

    task automatic test_zero_length();
        src.delete();
        run_xfer($urandom, 11'd0, 0, 100, 1'b0, -1);
    endtask

    task automatic test_wrap();
        fill_random(4);
        run_xfer(10'd1022, 11'd4, 0, 100, 1'b0, -1);
    endtask

    task automatic test_waitrequest();
        fill_random(6);
        run_xfer($urandom, 11'd6, 0, 100, 1'b0, 2);
    endtask

    task automatic test_ignore_start();
        fill_random(8);
        run_xfer($urandom, 11'd8, 0, 100, 1'b1, -1);
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 20);
            fill_random(n);
            run_xfer($urandom, 11'(n), 25, 70, t[0], -1);
        end
    endtask

    task automatic test_reset_mid();
        fill_random(5);
        @(negedge clk);
        load_start = 1'b1; base_addr = 10'd100; length = 11'd5; waitrequest = 1'b0;
        @(negedge clk);
        load_start = 1'b0; s_valid = 1'b1; s_data = src[0];
        @(negedge clk);
        s_data = src[1];
        @(negedge clk);
        mon_en = 1'b0;
        s_data = src[2];
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = src[2 + (i % 3)];
            @(negedge clk);
            vectors++;
            if (mem_enable !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_idle: got en=%b done=%b busy=%b rdy=%b expected 0 0 0 0",
                         mem_enable, done, busy, s_ready);
            end
        end
        s_valid = 1'b0;
        mon_en  = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        prev_ok     = 1'b0;
        prev_wr     = 1'b0;
        prev_bus    = '0;
        test_reset();
        test_basic();
        test_zero_length();
        test_wrap();
        test_waitrequest();
        test_ignore_start();
        test_reset_mid();
        test_basic();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
